vga_stream_sink: RTL and testbench

Avalon-ST sink that consumes the 640x480 30-bit pixel stream produced by the frame sources (face/image generators) and drives the VGA DAC pins with 640x480@60 timing. It owns the pixel timing, applies backpressure through `ready`, and locks the stream to the raster using `startofpacket`/`endofpacket`. It detects and recovers from misalignment and underflow.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_stream_sink_if.sv | 21 ++
 rtl/vga_timing_gen.sv | 65 ++++++
 rtl/vga_stream_sink.sv | 202 ++++++++++++++++++++
 tb/tb_vga_stream_sink.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, sink FSM states and the 30-bit pixel layout
// used by the VGA stream sink.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned H_CNT_W  = 10;
  localparam int unsigned V_CNT_W  = 10;
  localparam int unsigned COLOR_W  = 8;
  localparam int unsigned STAT_W   = 16;

  typedef enum logic [1:0] {
    SEARCH     = 2'd0,
    WAIT_FRAME = 2'd1,
    STREAM     = 2'd2
  } sink_state_t;

  // {R8,2'b00,G8,2'b00,B8,2'b00}
  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [1:0]         r_pad;
    logic [COLOR_W-1:0] g;
    logic [1:0]         g_pad;
    logic [COLOR_W-1:0] b;
    logic [1:0]         b_pad;
  } pixel30_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/vga_stream_sink_if.sv
// Avalon-ST pixel stream (readyLatency 0) between a frame source and the VGA sink.
interface vga_stream_sink_if;
  import vga_pkg::*;

  pixel30_t data;
  logic     startofpacket;
  logic     endofpacket;
  logic     valid;
  logic     ready;

  modport master (
    output data, startofpacket, endofpacket, valid,
    input  ready
  );

  modport slave (
    input  data, startofpacket, endofpacket, valid,
    output ready
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Free-running raster counters with unregistered active/hsync/vsync decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACT   = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FRONT = vga_pkg::H_FP,
  parameter int unsigned H_PULSE = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK  = vga_pkg::H_BP,
  parameter int unsigned V_ACT   = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FRONT = vga_pkg::V_FP,
  parameter int unsigned V_PULSE = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK  = vga_pkg::V_BP
) (
  input  logic               clk,
  input  logic               rst,
  output logic [H_CNT_W-1:0] h_cnt_o,
  output logic [V_CNT_W-1:0] v_cnt_o,
  output logic               active_c_o,
  output logic               hs_n_c_o,
  output logic               vs_n_c_o
);

  localparam int unsigned H_TOT    = H_ACT + H_FRONT + H_PULSE + H_BACK;
  localparam int unsigned V_TOT    = V_ACT + V_FRONT + V_PULSE + V_BACK;
  localparam int unsigned HS_START = H_ACT + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_PULSE;
  localparam int unsigned VS_START = V_ACT + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_PULSE;

  logic [H_CNT_W-1:0] h_q, h_d;
  logic [V_CNT_W-1:0] v_q, v_d;

  // h wraps at end of line and carries into v; v wraps at end of frame
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (h_q == H_CNT_W'(H_TOT - 1)) begin
      h_d = '0;
      if (v_q == V_CNT_W'(V_TOT - 1)) begin
        v_d = '0;
      end else begin
        v_d = v_q + V_CNT_W'(1);
      end
    end else begin
      h_d = h_q + H_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt_o    = h_q;
  assign v_cnt_o    = v_q;
  assign active_c_o = (h_q < H_CNT_W'(H_ACT)) && (v_q < V_CNT_W'(V_ACT));
  assign hs_n_c_o   = !((h_q >= H_CNT_W'(HS_START)) && (h_q < H_CNT_W'(HS_END)));
  assign vs_n_c_o   = !((v_q >= V_CNT_W'(VS_START)) && (v_q < V_CNT_W'(VS_END)));

endmodule

// File: rtl/vga_stream_sink.sv
// Avalon-ST pixel sink locking a SOP/EOP-framed stream to a free-running VGA raster.
// Optional statistics counters are built when VGA_SINK_STATS_EN is defined.
module vga_stream_sink
  import vga_pkg::*;
#(
  parameter int unsigned H_ACT   = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FRONT = vga_pkg::H_FP,
  parameter int unsigned H_PULSE = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK  = vga_pkg::H_BP,
  parameter int unsigned V_ACT   = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FRONT = vga_pkg::V_FP,
  parameter int unsigned V_PULSE = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK  = vga_pkg::V_BP
) (
  input  logic                clk,
  input  logic                reset,
  vga_stream_sink_if.slave    snk,
  output logic [COLOR_W-1:0]  vga_r,
  output logic [COLOR_W-1:0]  vga_g,
  output logic [COLOR_W-1:0]  vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_blank_n,
  output logic                in_sync,
  output logic                sync_err,
  output logic                underflow,
  output logic [STAT_W-1:0]   underflow_count,
  output logic [STAT_W-1:0]   resync_count
);

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               active_c;
  logic               hs_n_c;
  logic               vs_n_c;

  vga_timing_gen #(
    .H_ACT   (H_ACT),
    .H_FRONT (H_FRONT),
    .H_PULSE (H_PULSE),
    .H_BACK  (H_BACK),
    .V_ACT   (V_ACT),
    .V_FRONT (V_FRONT),
    .V_PULSE (V_PULSE),
    .V_BACK  (V_BACK)
  ) u_timing (
    .clk        (clk),
    .rst        (reset),
    .h_cnt_o    (h_cnt),
    .v_cnt_o    (v_cnt),
    .active_c_o (active_c),
    .hs_n_c_o   (hs_n_c),
    .vs_n_c_o   (vs_n_c)
  );

  sink_state_t        state_q, state_d;
  logic [3*COLOR_W-1:0] hold_q, hold_d;
  logic               hold_v_q, hold_v_d;
  logic [COLOR_W-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic               hs_q, vs_q, blank_n_q, in_sync_q;
  logic               sync_err_q, underflow_q;
  logic               sync_err_d, underflow_d;

  pixel30_t           beat;
  logic               at_origin_c, at_last_c;
  logic               ready_c, accept_c;
  logic               pad_unused_c;

  assign beat         = snk.data;
  assign pad_unused_c = ^{beat.r_pad, beat.g_pad, beat.b_pad};
  assign at_origin_c  = (h_cnt == '0) && (v_cnt == '0);
  assign at_last_c    = (h_cnt == H_CNT_W'(H_ACT - 1)) && (v_cnt == V_CNT_W'(V_ACT - 1));

  // ready is a function of state and raster position only, forced low during reset
  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      SEARCH:  ready_c = 1'b1;
      STREAM:  ready_c = active_c && !(hold_v_q && at_origin_c);
      default: ready_c = 1'b0;
    endcase
  end

  assign snk.ready = ready_c && !reset;
  assign accept_c  = snk.valid && ready_c && !reset;

  // next-state, hold register and pixel selection
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_v_d    = hold_v_q;
    r_d         = '0;
    g_d         = '0;
    b_d         = '0;
    sync_err_d  = 1'b0;
    underflow_d = 1'b0;
    case (state_q)
      SEARCH: begin
        if (accept_c && snk.startofpacket) begin
          hold_d   = {beat.r, beat.g, beat.b};
          hold_v_d = 1'b1;
          state_d  = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (at_origin_c) begin
          {r_d, g_d, b_d} = hold_q;
          hold_v_d        = 1'b0;
          state_d         = STREAM;
        end
      end
      STREAM: begin
        if (active_c) begin
          if (hold_v_q && at_origin_c) begin
            {r_d, g_d, b_d} = hold_q;
            hold_v_d        = 1'b0;
          end else if (accept_c) begin
            r_d = beat.r;
            g_d = beat.g;
            b_d = beat.b;
            // SOP misplacement wins over any EOP mismatch on the same beat
            if (snk.startofpacket && !at_origin_c) begin
              sync_err_d = 1'b1;
              hold_d     = {beat.r, beat.g, beat.b};
              hold_v_d   = 1'b1;
              state_d    = WAIT_FRAME;
            end else if ((!snk.startofpacket && at_origin_c) ||
                         (snk.endofpacket != at_last_c)) begin
              sync_err_d = 1'b1;
              state_d    = SEARCH;
            end
          end else begin
            underflow_d = 1'b1;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      hold_q      <= '0;
      hold_v_q    <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_n_q   <= 1'b0;
      in_sync_q   <= 1'b0;
      sync_err_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      hs_q        <= hs_n_c;
      vs_q        <= vs_n_c;
      blank_n_q   <= active_c;
      in_sync_q   <= (state_d == STREAM);
      sync_err_q  <= sync_err_d;
      underflow_q <= underflow_d;
    end
  end

  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign in_sync     = in_sync_q;
  assign sync_err    = sync_err_q;
  assign underflow   = underflow_q;

`ifdef VGA_SINK_STATS_EN
  logic [STAT_W-1:0] uf_cnt_q, rs_cnt_q;

  // saturating event counters, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uf_cnt_q <= '0;
      rs_cnt_q <= '0;
    end else begin
      if (underflow_d) uf_cnt_q <= sat_inc(uf_cnt_q);
      if (sync_err_d)  rs_cnt_q <= sat_inc(rs_cnt_q);
    end
  end

  assign underflow_count = uf_cnt_q;
  assign resync_count    = rs_cnt_q;
`else
  assign underflow_count = '0;
  assign resync_count    = '0;
`endif

endmodule

// File: tb/tb_vga_stream_sink.sv
// Randomised scoreboard bench for vga_stream_sink on a shrunken raster.
module tb_vga_stream_sink;
  import vga_pkg::*;

  localparam int unsigned HA = 16, HF = 2, HSW = 4, HB = 3;
  localparam int unsigned VA = 6,  VF = 1, VSW = 2, VB = 2;
  localparam int unsigned HT = HA + HF + HSW + HB;
  localparam int unsigned VT = VA + VF + VSW + VB;
  localparam int unsigned FT = HT * VT;
  localparam int unsigned NB = HA * VA;
  localparam int M_SEARCH = 0, M_WAIT = 1, M_STREAM = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_stream_sink_if st_if();
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, in_sync, sync_err, underflow;
  logic [15:0] underflow_count, resync_count;

  vga_stream_sink #(
    .H_ACT(HA), .H_FRONT(HF), .H_PULSE(HSW), .H_BACK(HB),
    .V_ACT(VA), .V_FRONT(VF), .V_PULSE(VSW), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .snk(st_if.slave),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .in_sync(in_sync), .sync_err(sync_err), .underflow(underflow),
    .underflow_count(underflow_count), .resync_count(resync_count)
  );

  typedef struct {
    int          pos;
    logic [63:0] pins;
  } exp_t;

  exp_t sbq[$];
  int total = 0, bad = 0;

  // reference model: raster position, lock mode, one held pixel, event totals
  int          pos, mode, m_uf, m_rs;
  bit          hv;
  logic [23:0] held;
  // source: frame beat index and the data of the pending beat
  int          src_beat;
  pixel30_t    src_data;
  // monitor observations inside a measurement window
  int obs_uf, obs_se, obs_hs_low, obs_vs_low, obs_rgb_nz;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] dut_pins();
    return 64'({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, in_sync,
                sync_err, underflow, underflow_count, resync_count});
  endfunction

  function automatic logic [63:0] reset_pins();
    return 64'({24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0});
  endfunction

  // monitor: pops one expectation per clock and compares the registered pins
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check($sformatf("pins x=%0d y=%0d", e.pos % HT, e.pos / HT), dut_pins(), e.pins);
        if (underflow) obs_uf++;
        if (sync_err) obs_se++;
        if (!vga_hs) obs_hs_low++;
        if (!vga_vs) obs_vs_low++;
        if ({vga_r, vga_g, vga_b} != 24'h0) obs_rgb_nz++;
      end
    end
  end

  task automatic win_start();
    obs_uf = 0; obs_se = 0; obs_hs_low = 0; obs_vs_low = 0; obs_rgb_nz = 0;
  endtask

  task automatic win_end();
    @(posedge clk);
    #2;
  endtask

  // one pixel clock: drive the source, predict ready and the next pins
  task automatic step(input bit v, input int sel);
    int x, y;
    bit act, org, last, rdy, acc, sop, eop, se, uf, hs, vs;
    logic [23:0] pix, rgb;
    logic [15:0] ucnt, rcnt;
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    x = pos % HT;
    y = pos / HT;
    sop = (src_beat == 0) || (sel == 1);
    eop = (src_beat == NB - 1) && (sel != 2);
    st_if.valid = v;
    st_if.data = src_data;
    st_if.startofpacket = sop;
    st_if.endofpacket = eop;
    #1;
    act  = (x < HA) && (y < VA);
    org  = (pos == 0);
    last = (x == HA - 1) && (y == VA - 1);
    rdy  = (mode == M_SEARCH) || (mode == M_STREAM && act && !(hv && org));
    check("ready", 64'(st_if.ready), 64'(rdy));
    acc = v && rdy;
    rgb = {src_data.r, src_data.g, src_data.b};
    pix = 24'h0; se = 1'b0; uf = 1'b0;
    if (mode == M_SEARCH) begin
      if (acc && sop) begin held = rgb; hv = 1'b1; mode = M_WAIT; end
    end else if (mode == M_WAIT) begin
      if (org) begin pix = held; hv = 1'b0; mode = M_STREAM; end
    end else if (act) begin
      if (hv && org) begin
        pix = held; hv = 1'b0;
      end else if (!v) begin
        uf = 1'b1;
      end else begin
        pix = rgb;
        if (sop && !org) begin
          se = 1'b1; held = rgb; hv = 1'b1; mode = M_WAIT;
        end else if ((!sop && org) || (eop != last)) begin
          se = 1'b1; mode = M_SEARCH;
        end
      end
    end
    if (acc) begin
      src_beat = (src_beat + 1) % NB;
      src_data = pixel30_t'(30'($urandom));
    end
    if (uf && m_uf < 65535) m_uf++;
    if (se && m_rs < 65535) m_rs++;
`ifdef VGA_SINK_STATS_EN
    ucnt = 16'(m_uf);
    rcnt = 16'(m_rs);
`else
    ucnt = 16'h0;
    rcnt = 16'h0;
`endif
    hs = !((x >= HA + HF) && (x < HA + HF + HSW));
    vs = !((y >= VA + VF) && (y < VA + VF + VSW));
    e.pos  = pos;
    e.pins = 64'({pix, hs, vs, act, (mode == M_STREAM), se, uf, ucnt, rcnt});
    sbq.push_back(e);
    pos = (pos + 1) % FT;
  endtask

  task automatic run_until(input int target);
    while (pos != target) step(1'b1, 0);
  endtask

  // assert reset at a negedge; pins must drop to reset values without a clock
  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1;
    st_if.valid = 1'b0;
    #1;
    check("rst_pins", dut_pins(), reset_pins());
    check("rst_ready", 64'(st_if.ready), 64'(0));
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check("rst_hold_pins", dut_pins(), reset_pins());
    end
    pos = 0; mode = M_SEARCH; hv = 1'b0; held = 24'h0;
    m_uf = 0; m_rs = 0; src_beat = 0;
  endtask

  initial begin
    logic [23:0] inj;
    reset = 1'b1;
    st_if.valid = 1'b0;
    st_if.data = '0;
    st_if.startofpacket = 1'b0;
    st_if.endofpacket = 1'b0;
    src_data = pixel30_t'(30'($urandom));

    do_reset(2);

    // timing only: no beats, syncs must still run with black video
    win_start();
    repeat (2 * FT) step(1'b0, 0);
    win_end();
    check("hs_low_cycles", 64'(obs_hs_low), 64'(2 * VT * HSW));
    check("vs_low_cycles", 64'(obs_vs_low), 64'(2 * VSW * HT));
    check("rgb_black", 64'(obs_rgb_nz), 64'(0));

    // ideal source locks by the second frame with no errors
    win_start();
    repeat (3 * FT) step(1'b1, 0);
    win_end();
    check("ideal_in_sync", 64'(in_sync), 64'(1));
    check("ideal_sync_err", 64'(obs_se), 64'(0));
    check("ideal_underflow", 64'(obs_uf), 64'(0));

    // five-beat starvation mid-line 3, then relock
    run_until(3 * HT + 5);
    win_start();
    repeat (5) step(1'b0, 0);
    repeat (3 * FT) step(1'b1, 0);
    win_end();
    check("gap_underflow", 64'(obs_uf), 64'(5));
    check("gap_sync_err", 64'(obs_se), 64'(1));
    check("gap_relock", 64'(in_sync), 64'(1));

    // stray SOP on beat 20 is shown at the next frame origin
    while (src_beat != 20) step(1'b1, 0);
    inj = {src_data.r, src_data.g, src_data.b};
    win_start();
    step(1'b1, 1);
    while (pos != 0) step(1'b1, 0);
    step(1'b1, 0);
    @(posedge clk);
    #2;
    check("sop_origin_pixel", 64'({vga_r, vga_g, vga_b}), 64'(inj));
    check("sop_in_sync", 64'(in_sync), 64'(1));
    repeat (2 * FT) step(1'b1, 0);
    win_end();
    check("sop_sync_err", 64'(obs_se), 64'(2));
    check("sop_relock", 64'(in_sync), 64'(1));

    // missing EOP on the last beat drops back to SEARCH
    run_until((VA - 1) * HT + HA - 1);
    step(1'b1, 2);
    @(posedge clk);
    #2;
    check("eop_sync_err", 64'(sync_err), 64'(1));
    check("eop_in_sync", 64'(in_sync), 64'(0));
    repeat (2 * FT) step(1'b1, 0);
    win_end();
    check("eop_relock", 64'(in_sync), 64'(1));

    // random valid gaps with occasional stray SOP / dropped EOP
    repeat (10 * FT) begin
      int r;
      r = int'($urandom_range(0, 99));
      step($urandom_range(0, 9) != 0, (r == 0) ? 1 : ((r == 1) ? 2 : 0));
    end
    repeat (4 * FT) step(1'b1, 0);
    win_end();
    check("rand_relock", 64'(in_sync), 64'(1));

    // reset in the middle of the visible area, raster restarts from origin
    run_until((VA / 2) * HT + HA / 2);
    do_reset(3);
    win_start();
    repeat (3 * FT) step(1'b1, 0);
    win_end();
    check("post_rst_in_sync", 64'(in_sync), 64'(1));
    check("post_rst_sync_err", 64'(obs_se), 64'(0));
    check("post_rst_underflow", 64'(obs_uf), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
